// File: rtl/gpu_pipe_pkg.sv
// Shared helpers for GPU stage controllers: width function and stage control encodings.
package gpu_pipe_pkg;

  localparam logic [1:0] CTL_RUN   = 2'd0;
  localparam logic [1:0] CTL_STALL = 2'd1;
  localparam logic [1:0] CTL_FLUSH = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/pipeline_flow_ctrl_stage.sv
// One pipeline stage: valid bit plus sideband tag, loaded on enable, cleared by flush.
module pipe_stage_reg #(
  parameter int TAG_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_vld,
  output logic [TAG_W-1:0] o_tag
);

  // Flush only drops validity; tags stay stale until the next load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_vld <= 1'b0;
      o_tag <= '0;
    end else if (i_flush) begin
      o_vld <= 1'b0;
    end else if (i_en) begin
      o_vld <= i_vld;
      o_tag <= i_tag;
    end
  end

endmodule

// File: rtl/pipeline_flow_ctrl.sv
// Valid/ready controller for DEPTH datapath stages: bubble collapse, backpressure, flush, occupancy.
module pipeline_flow_ctrl
  import gpu_pipe_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int TAG_W = 8,
  localparam int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_in_ready,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic [DEPTH-1:0] o_stage_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_idle
);

  // Index 0 is the upstream input; index g+1 is the output of stage g.
  logic [DEPTH:0]            vld_chain;
  logic [DEPTH:0][TAG_W-1:0] tag_chain;
  logic [DEPTH-1:0]          adv;
  logic [1:0]                ctl;
  logic [CNT_W-1:0]          cnt;
  logic                      in_xfer, out_xfer;

  assign vld_chain[0] = i_valid;
  assign tag_chain[0] = i_tag;

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    // A stage moves when any stage at or ahead of it has a hole, or the sink accepts.
    assign adv[g] = i_ready | ~(&vld_chain[DEPTH:g+1]);

    pipe_stage_reg #(.TAG_W(TAG_W)) u_stage (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (o_stage_en[g]),
      .i_flush (i_flush),
      .i_vld   (vld_chain[g]),
      .i_tag   (tag_chain[g]),
      .o_vld   (vld_chain[g+1]),
      .o_tag   (tag_chain[g+1])
    );
  end

  always_comb begin
    ctl = CTL_RUN;
    if (i_flush)      ctl = CTL_FLUSH;
    else if (!adv[0]) ctl = CTL_STALL;
  end

  assign o_in_ready = i_rst_n & (ctl == CTL_RUN);
  assign o_valid    = vld_chain[DEPTH] & ~i_flush;
  assign o_tag      = tag_chain[DEPTH];
  assign o_stage_en = adv & {DEPTH{~i_flush & i_rst_n}};
  assign in_xfer    = i_valid & o_in_ready;
  assign out_xfer   = o_valid & i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                cnt <= '0;
    else if (ctl == CTL_FLUSH)   cnt <= '0;
    else                         cnt <= cnt + CNT_W'(in_xfer) - CNT_W'(out_xfer);
  end

  assign o_count = cnt;
  assign o_idle  = (cnt == '0);

  a_count_matches_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (32'(cnt) == $countones(vld_chain[DEPTH:1])) && (32'(cnt) <= DEPTH));

endmodule

// File: tb/tb_pipeline_flow_ctrl.sv
// Randomized and directed checks of pipeline_flow_ctrl against a slot/queue model.
module tb_pipeline_flow_ctrl;
  localparam int D  = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, a_flush, a_in_ready, a_o_valid, a_idle;
  logic [TW-1:0] a_tag, a_o_tag;
  logic [D-1:0]  a_stage_en;
  logic [2:0]    a_count;
  logic          b_valid, b_ready, b_flush, b_in_ready, b_o_valid, b_idle;
  logic [TW-1:0] b_tag, b_o_tag;
  logic [0:0]    b_stage_en;
  logic [0:0]    b_count;

  always #5 clk = ~clk;

  pipeline_flow_ctrl #(.DEPTH(D), .TAG_W(TW)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(a_valid), .i_tag(a_tag),
    .o_in_ready(a_in_ready), .o_valid(a_o_valid), .o_tag(a_o_tag),
    .i_ready(a_ready), .i_flush(a_flush), .o_stage_en(a_stage_en),
    .o_count(a_count), .o_idle(a_idle));

  pipeline_flow_ctrl #(.DEPTH(1), .TAG_W(TW)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .i_tag(b_tag),
    .o_in_ready(b_in_ready), .o_valid(b_o_valid), .o_tag(b_o_tag),
    .i_ready(b_ready), .i_flush(b_flush), .o_stage_en(b_stage_en),
    .o_count(b_count), .o_idle(b_idle));

  // Model: slot occupancy for timing, a FIFO of accepted tags for order and count.
  bit            m_v [D];
  logic [TW-1:0] m_t [D];
  logic [TW-1:0] q [$];
  bit            e_in_ready, e_valid;
  int            vec = 0, err = 0;

  task automatic chk(input string name, input int act, input int exp);
    vec++;
    if (act != exp) begin
      err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int occ_from(input int j);
    int n = 0;
    for (int k = j; k < D; k++) n += int'(m_v[k]);
    return n;
  endfunction

  function automatic bit moves(input int j, input bit rd);
    return rd || (occ_from(j) < D - j);
  endfunction

  task automatic clear_model();
    for (int j = 0; j < D; j++) begin m_v[j] = 1'b0; m_t[j] = '0; end
    q.delete();
  endtask

  task automatic drive(input bit r, input bit v, input logic [TW-1:0] t, input bit rd, input bit f);
    int en;
    @(negedge clk);
    rst_n = r; a_valid = v; a_tag = t; a_ready = rd; a_flush = f;
    if (!r) clear_model();
    #1;
    e_in_ready = r && !f && moves(0, rd);
    e_valid    = m_v[D-1] && !f;
    en = 0;
    for (int j = 0; j < D; j++) if (r && !f && moves(j, rd)) en |= (1 << j);
    chk("in_ready", int'(a_in_ready), int'(e_in_ready));
    chk("valid", int'(a_o_valid), int'(e_valid));
    chk("tag", int'(a_o_tag), int'(m_t[D-1]));
    chk("stage_en", int'(a_stage_en), en);
    chk("count", int'(a_count), q.size());
    chk("idle", int'(a_idle), int'(q.size() == 0));
    if (e_valid && rd) chk("order", int'(a_o_tag), (q.size() > 0) ? int'(q[0]) : 256);
  endtask

  task automatic step();
    bit            ov [D];
    logic [TW-1:0] ot [D];
    bit            mv [D];
    @(posedge clk);
    if (rst_n) begin
      if (a_flush) begin
        for (int j = 0; j < D; j++) m_v[j] = 1'b0;
        q.delete();
      end else begin
        for (int j = 0; j < D; j++) begin ov[j] = m_v[j]; ot[j] = m_t[j]; mv[j] = moves(j, a_ready); end
        for (int j = 0; j < D; j++) if (mv[j]) begin
          m_v[j] = (j == 0) ? a_valid : ov[j-1];
          m_t[j] = (j == 0) ? a_tag   : ot[j-1];
        end
        if (e_valid && a_ready && q.size() > 0) void'(q.pop_front());
        if (a_valid && e_in_ready) q.push_back(a_tag);
      end
    end
  endtask

  initial begin
    int  k;
    bit  acc;
    b_valid = 0; b_tag = '0; b_ready = 0; b_flush = 0;
    clear_model();

    // Reset state
    drive(0, 0, 8'h00, 0, 0);
    chk("rst_idle", int'(a_idle), 1);
    chk("rst_stage_en", int'(a_stage_en), 0);
    step();
    drive(0, 0, 8'h00, 0, 0); step();

    // Stream at full rate: first token appears DEPTH cycles after acceptance
    for (int c = 0; c < 13; c++) begin
      drive(1, c < 8, TW'(8'h10 + c), 1, 0);
      if (c >= 4 && c < 12) begin
        chk("stream_valid", int'(a_o_valid), 1);
        chk("stream_tag", int'(a_o_tag), 8'h10 + c - 4);
      end
      step();
    end

    // Backpressure: 6 offered, 4 accepted while stalled
    k = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1, 1, TW'(8'h30 + k), 0, 0);
      if (c == 6) begin
        chk("bp_in_ready", int'(a_in_ready), 0);
        chk("bp_count", int'(a_count), 4);
        chk("bp_head", int'(a_o_tag), 8'h30);
      end
      acc = e_in_ready; step(); if (acc) k++;
    end
    for (int c = 0; c < 12; c++) begin
      drive(1, k < 6, TW'(8'h30 + k), 1, 0);
      acc = e_in_ready; step(); if (acc) k++;
    end

    // Bubble collapse
    drive(1, 1, 8'h20, 1, 0); step();
    drive(1, 0, 8'h00, 1, 0); step();
    drive(1, 1, 8'h21, 1, 0); step();
    drive(1, 0, 8'h00, 0, 0); step();
    drive(1, 0, 8'h00, 0, 0); step();
    drive(1, 0, 8'h00, 0, 0);
    chk("bub_valid", int'(a_o_valid), 1);
    chk("bub_tag", int'(a_o_tag), 8'h20);
    chk("bub_count", int'(a_count), 2);
    chk("bub_stage_en", int'(a_stage_en), 4'b0011);
    step();
    for (int c = 0; c < 6; c++) begin drive(1, 0, 8'h00, 1, 0); step(); end

    // Flush a full pipeline with simultaneous valid/ready
    for (int c = 0; c < 4; c++) begin drive(1, 1, TW'(8'h40 + c), 0, 0); step(); end
    drive(1, 1, 8'h50, 1, 1);
    chk("fl_in_ready", int'(a_in_ready), 0);
    chk("fl_valid", int'(a_o_valid), 0);
    chk("fl_stage_en", int'(a_stage_en), 0);
    step();
    drive(1, 0, 8'h00, 0, 0);
    chk("fl_count", int'(a_count), 0);
    chk("fl_idle", int'(a_idle), 1);
    step();

    // Reset with 3 tokens in flight
    for (int c = 0; c < 3; c++) begin drive(1, 1, TW'(8'h60 + c), 0, 0); step(); end
    drive(0, 1, 8'h66, 1, 0);
    chk("mrst_valid", int'(a_o_valid), 0);
    chk("mrst_count", int'(a_count), 0);
    chk("mrst_idle", int'(a_idle), 1);
    step();
    drive(1, 0, 8'h00, 1, 0);
    chk("mrst_tag", int'(a_o_tag), 0);
    step();

    // Randomized traffic
    for (int c = 0; c < 500; c++) begin
      drive(($urandom % 97) != 0, ($urandom % 4) != 0, TW'($urandom),
            (c % 64 < 20) ? (($urandom % 4) == 0) : (($urandom % 3) != 0),
            ($urandom % 23) == 0);
      step();
    end
    for (int c = 0; c < 8; c++) begin drive(1, 0, 8'h00, 1, 0); step(); end

    // DEPTH=1 build
    @(negedge clk); b_valid = 1; b_tag = 8'hA5; b_ready = 1; #1;
    chk("d1_in_ready", int'(b_in_ready), 1);
    chk("d1_valid0", int'(b_o_valid), 0);
    @(posedge clk);
    for (int c = 1; c < 5; c++) begin
      @(negedge clk); b_tag = TW'(8'hA5 + c); #1;
      chk("d1_valid", int'(b_o_valid), 1);
      chk("d1_tag", int'(b_o_tag), 8'hA5 + c - 1);
      chk("d1_count", int'(b_count), 1);
      @(posedge clk);
    end
    @(negedge clk); b_valid = 0; #1;
    chk("d1_last_tag", int'(b_o_tag), 8'hA9);
    @(posedge clk);
    @(negedge clk); #1;
    chk("d1_idle", int'(b_idle), 1);
    chk("d1_valid_end", int'(b_o_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
